// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: state sequencing, memory wait/timeout and datapath control decode.
// Optional trap on illegal opcodes is enabled by defining MC_CTRL_TRAP_EN.
module mc_ctrl_fsm #(
   parameter int unsigned OP_W    = 6,
   parameter int unsigned ALUOP_W = 3,
   parameter int unsigned TMO_W   = 4,
   parameter int unsigned MEM_TMO = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    op,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_wr_cond,
   output logic               br_ne,
   output logic [1:0]         pc_src,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic [1:0]         mem_to_reg,
   output logic [1:0]         reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               ext_zero,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               retire,
   output logic               mem_err,
   output logic [3:0]         state
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRd = 4'd3,
      StMemWb  = 4'd4,  StMemWr  = 4'd5,  StRex    = 4'd6,  StRwb   = 4'd7,
      StBeq    = 4'd8,  StBne    = 4'd9,  StJump   = 4'd10, StIex   = 4'd11,
      StIwb    = 4'd12, StJal    = 4'd13, StTrap   = 4'd14
   } state_e;

   localparam logic [OP_W-1:0] OpR    = OP_W'(8'h00);
   localparam logic [OP_W-1:0] OpJ    = OP_W'(8'h02);
   localparam logic [OP_W-1:0] OpJal  = OP_W'(8'h03);
   localparam logic [OP_W-1:0] OpBeq  = OP_W'(8'h04);
   localparam logic [OP_W-1:0] OpBne  = OP_W'(8'h05);
   localparam logic [OP_W-1:0] OpAddi = OP_W'(8'h08);
   localparam logic [OP_W-1:0] OpAndi = OP_W'(8'h0C);
   localparam logic [OP_W-1:0] OpOri  = OP_W'(8'h0D);
   localparam logic [OP_W-1:0] OpLw   = OP_W'(8'h23);
   localparam logic [OP_W-1:0] OpSw   = OP_W'(8'h2B);

   localparam logic [ALUOP_W-1:0] AluAdd   = ALUOP_W'(3'b000);
   localparam logic [ALUOP_W-1:0] AluSub   = ALUOP_W'(3'b001);
   localparam logic [ALUOP_W-1:0] AluFunct = ALUOP_W'(3'b010);
   localparam logic [ALUOP_W-1:0] AluAnd   = ALUOP_W'(3'b011);
   localparam logic [ALUOP_W-1:0] AluOr    = ALUOP_W'(3'b100);

   state_e           state_q, state_d;
   logic [TMO_W-1:0] wait_q;
   logic             mem_wait, timeout, op_legal;

   assign state    = state_q;
   assign op_legal = op inside {OpR, OpJ, OpJal, OpBeq, OpBne, OpAddi, OpAndi, OpOri, OpLw, OpSw};
   assign mem_wait = (state_q inside {StFetch, StMemRd, StMemWr}) && !mem_ready;
   assign timeout  = mem_wait && (MEM_TMO != 0) && (wait_q == TMO_W'(MEM_TMO));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch:  if (mem_ready) state_d = StDecode;
         StDecode: begin
            if (op == OpLw || op == OpSw)                        state_d = StMemAdr;
            else if (op == OpR)                                  state_d = StRex;
            else if (op == OpBeq)                                state_d = StBeq;
            else if (op == OpBne)                                state_d = StBne;
            else if (op == OpJ)                                  state_d = StJump;
            else if (op == OpJal)                                state_d = StJal;
            else if (op == OpAddi || op == OpAndi || op == OpOri) state_d = StIex;
            else begin
`ifdef MC_CTRL_TRAP_EN
               state_d = StTrap;
`else
               state_d = StFetch;
`endif
            end
         end
         StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
         StMemRd:  if (mem_ready) state_d = StMemWb;
         StMemWr:  if (mem_ready) state_d = StFetch;
         StRex:    state_d = StRwb;
         StIex:    state_d = StIwb;
         default:  state_d = StFetch;
      endcase
      if (timeout) state_d = StFetch;
   end

   // Wait counter restarts whenever the state changes or a timeout aborts back to FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q || timeout) wait_q <= '0;
         else if (mem_wait)                 wait_q <= wait_q + 1'b1;
      end
   end

   always_comb begin
      pc_write   = 1'b0;
      pc_wr_cond = 1'b0;
      br_ne      = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 2'b00;
      reg_dst    = 2'b00;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_zero   = 1'b0;
      alu_op     = AluAdd;
      retire     = 1'b0;
      unique case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready && rst_n;
            pc_write  = mem_ready && rst_n;
         end
         StDecode: begin
            alu_src_b = 2'b11;
`ifndef MC_CTRL_TRAP_EN
            retire    = !op_legal;
`endif
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         StMemRd: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            retire     = 1'b1;
         end
         StMemWr: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            retire    = mem_ready;
         end
         StRex: begin
            alu_src_a = 1'b1;
            alu_op    = AluFunct;
         end
         StRwb: begin
            reg_write = 1'b1;
            reg_dst   = 2'b01;
            retire    = 1'b1;
         end
         StBeq, StBne: begin
            alu_src_a  = 1'b1;
            alu_op     = AluSub;
            pc_wr_cond = 1'b1;
            pc_src     = 2'b01;
            br_ne      = (state_q == StBne);
            retire     = 1'b1;
         end
         StJump: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            retire   = 1'b1;
         end
         StJal: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            retire     = 1'b1;
         end
         StIex: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            ext_zero  = (op == OpAndi) || (op == OpOri);
            alu_op    = (op == OpAndi) ? AluAnd : (op == OpOri) ? AluOr : AluAdd;
         end
         StIwb: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         StTrap: begin
            pc_write = 1'b1;
            pc_src   = 2'b11;
         end
         default: ;
      endcase
      // A timed-out access commits nothing; selects keep their state decode.
      if (timeout) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         retire    = 1'b0;
      end
   end

   assign mem_err = timeout;

endmodule
